// File: rtl/timing_gen_if.sv
// Control and phase-drive bundle between the LVDA master timing generator
// and its consumers (fan-out/driver modules and run/step control).
interface timing_gen_if;
    logic       RUN;
    logic       STEP;
    logic       WDA;
    logic       XDA;
    logic       YDA;
    logic       ZDA;
    logic [3:0] BIT;
    logic [1:0] PHS;
    logic       PHASE_END;
    logic       CYC_END;
    logic       HALTED;

    modport master (
        input  RUN, STEP,
        output WDA, XDA, YDA, ZDA, BIT, PHS, PHASE_END, CYC_END, HALTED
    );

    modport slave (
        output RUN, STEP,
        input  WDA, XDA, YDA, ZDA, BIT, PHS, PHASE_END, CYC_END, HALTED
    );
endinterface

// File: rtl/timing_gen.sv
// LVDA master timing generator: W/X/Y/Z slot drives, bit-time and phase
// counters, with run / halt-at-cycle-end / single-cycle step control.
module timing_gen #(
    parameter int CLKS_PER_SLOT  = 2,
    parameter int BITS_PER_PHASE = 14,
    parameter int PHASES         = 3
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST,
    timing_gen_if.master  tg
);
    localparam logic [3:0] DIV_LAST = 4'(CLKS_PER_SLOT - 1);
    localparam logic [3:0] BIT_LAST = 4'(BITS_PER_PHASE - 1);
    localparam logic [1:0] PHS_LAST = 2'(PHASES - 1);

    typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_t;

    state_t     st;
    logic [3:0] da;      // one-hot {Z,Y,X,W}
    logic [3:0] div;
    logic [3:0] bit_q;
    logic [1:0] phs;
    logic       pe, ce, halted;

    logic [3:0] adv_div, adv_da, adv_bit;
    logic [1:0] adv_phs;
    logic       adv_pe, adv_ce, slot_done, bit_done;

    // Position one clock further along the cycle; wraps to W/0/0 after the last clock.
    always_comb begin
        slot_done = (div == DIV_LAST);
        bit_done  = slot_done && da[3];
        adv_div   = slot_done ? 4'd0 : div + 4'd1;
        adv_da    = slot_done ? {da[2:0], da[3]} : da;
        adv_bit   = bit_q;
        adv_phs   = phs;
        if (bit_done) begin
            if (bit_q == BIT_LAST) begin
                adv_bit = 4'd0;
                adv_phs = (phs == PHS_LAST) ? 2'd0 : phs + 2'd1;
            end else begin
                adv_bit = bit_q + 4'd1;
            end
        end
        adv_pe = adv_da[3] && (adv_div == DIV_LAST) && (adv_bit == BIT_LAST);
        adv_ce = adv_pe && (adv_phs == PHS_LAST);
    end

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            st     <= S_HALTED;
            da     <= 4'd0;
            div    <= 4'd0;
            bit_q  <= 4'd0;
            phs    <= 2'd0;
            pe     <= 1'b0;
            ce     <= 1'b0;
            halted <= 1'b1;
        end else begin
            case (st)
                S_HALTED: begin
                    if (tg.RUN || tg.STEP) begin
                        st     <= tg.RUN ? S_RUN : S_STEP;
                        da     <= 4'b0001;
                        div    <= 4'd0;
                        bit_q  <= 4'd0;
                        phs    <= 2'd0;
                        pe     <= 1'b0;
                        ce     <= 1'b0;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    // RUN is only looked at on the cycle-end clock, so a drop mid-cycle just arms the halt.
                    if (ce && !tg.RUN) begin
                        st     <= S_HALTED;
                        da     <= 4'd0;
                        div    <= 4'd0;
                        bit_q  <= 4'd0;
                        phs    <= 2'd0;
                        pe     <= 1'b0;
                        ce     <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        if (ce) st <= S_RUN;
                        da    <= adv_da;
                        div   <= adv_div;
                        bit_q <= adv_bit;
                        phs   <= adv_phs;
                        pe    <= adv_pe;
                        ce    <= adv_ce;
                    end
                end
            endcase
        end
    end

    assign tg.WDA       = da[0];
    assign tg.XDA       = da[1];
    assign tg.YDA       = da[2];
    assign tg.ZDA       = da[3];
    assign tg.BIT       = bit_q;
    assign tg.PHS       = phs;
    assign tg.PHASE_END = pe;
    assign tg.CYC_END   = ce;
    assign tg.HALTED    = halted;
endmodule
